// File: rtl/ov7670_snapshot_ctrl_if.sv
// rtl/ov7670_snapshot_ctrl_if.sv - capture-side and frame-buffer write-port signals
interface ov7670_snapshot_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;

  modport master (
    output cap_addr, cap_data, cap_we,
    input  bram_addr, bram_data, bram_we
  );

  modport slave (
    input  cap_addr, cap_data, cap_we,
    output bram_addr, bram_data, bram_we
  );
endinterface

// File: rtl/ov7670_snapshot_ctrl.sv
// rtl/ov7670_snapshot_ctrl.sv - live pass-through / single-frame snapshot gate for the OV7670 frame buffer
module ov7670_snapshot_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic                 vsync,
  input  logic                 snap_req,
  input  logic                 live_req,
  ov7670_snapshot_ctrl_if.slave bus,
  output logic                 freeze_frame,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ADDR_W-1:0]    pixel_count,
  output logic [15:0]          frame_count,
  output logic                 short_frame
);

  localparam int                FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam logic [ADDR_W:0]   FRAME_LIMIT  = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] PIX_MAX      = ADDR_W'(FRAME_PIXELS);

  typedef enum logic [1:0] {S_LIVE, S_ARMED, S_CAPTURE, S_HOLD} state_t;

  state_t            state, state_next;
  logic              vsync_q, sof, eof, pass, in_range, accept;
  logic [ADDR_W-1:0] pixel_count_next;

  assign sof      = ~vsync & vsync_q;
  assign eof      = vsync & ~vsync_q;
  assign in_range = {1'b0, bus.cap_addr} < FRAME_LIMIT;
  assign accept   = bus.cap_we & in_range & (state == S_CAPTURE);
  // Counter stops at a full frame; surplus writes still pass if their address is legal.
  assign pixel_count_next = (accept && (pixel_count != PIX_MAX)) ?
                            pixel_count + ADDR_W'(1) : pixel_count;

  always_ff @(posedge pclk) begin
    if (!reset_n) state <= S_LIVE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LIVE:    if (snap_req) state_next = S_ARMED;
      S_ARMED: begin
        if (live_req)  state_next = S_LIVE;
        else if (sof)  state_next = S_CAPTURE;
      end
      S_CAPTURE: if (eof) state_next = S_HOLD;
      S_HOLD: begin
        if (snap_req)      state_next = S_ARMED;
        else if (live_req) state_next = S_LIVE;
      end
      default:   state_next = S_LIVE;
    endcase
  end

  always_comb begin
    pass         = (state == S_LIVE) || (state == S_CAPTURE);
    busy         = (state == S_ARMED) || (state == S_CAPTURE);
    freeze_frame = (state == S_HOLD);
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      vsync_q       <= 1'b1;
      bus.bram_addr <= '0;
      bus.bram_data <= '0;
      bus.bram_we   <= 1'b0;
      frame_done    <= 1'b0;
      pixel_count   <= '0;
      frame_count   <= '0;
      short_frame   <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      bus.bram_addr <= bus.cap_addr;
      bus.bram_data <= bus.cap_data;
      bus.bram_we   <= bus.cap_we & pass & in_range;
      frame_done    <= (state == S_CAPTURE) & eof;
      if (eof) frame_count <= frame_count + 16'd1;
      if ((state == S_ARMED) && (state_next == S_CAPTURE)) pixel_count <= '0;
      else                                                 pixel_count <= pixel_count_next;
      if ((state == S_CAPTURE) && eof) short_frame <= (pixel_count_next != PIX_MAX);
    end
  end

endmodule

// File: tb/tb_ov7670_snapshot_ctrl.sv
// tb/tb_ov7670_snapshot_ctrl.sv - self-checking bench for ov7670_snapshot_ctrl on a reduced 8x4 frame
module tb_ov7670_snapshot_ctrl;
  localparam int H = 8;
  localparam int V = 4;
  localparam int FP = H * V;
  localparam int AW = 8;
  localparam int DW = 12;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int n_in;
    int n_oor;
    bit we_on_eof;
    int exp_pixels;
    bit exp_short;
  } vec_t;

  logic pclk = 1'b0;
  logic reset_n, vsync, snap_req, live_req;
  logic freeze_frame, busy, frame_done, short_frame;
  logic [AW-1:0] pixel_count;
  logic [15:0] frame_count;

  ov7670_snapshot_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ov7670_snapshot_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .snap_req(snap_req), .live_req(live_req),
    .bus(bus), .freeze_frame(freeze_frame), .busy(busy), .frame_done(frame_done),
    .pixel_count(pixel_count), .frame_count(frame_count), .short_frame(short_frame)
  );

  always #5 pclk = ~pclk;

  int n_pass = 0;
  int n_total = 0;
  int done_pulses = 0;
  int model_frames = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic raise_vsync();
    vsync = 1'b1;
    model_frames++;
  endtask

  task automatic pulse(input bit s, input bit l);
    snap_req = s;
    live_req = l;
    step(1);
    snap_req = 1'b0;
    live_req = 1'b0;
  endtask

  // Scoreboard: every frame-buffer write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (bus.bram_we === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_write", 32'(bus.bram_we), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("bram_addr", 32'(bus.bram_addr), 32'(e.addr));
          check("bram_data", 32'(bus.bram_data), 32'(e.data));
        end
      end
      if (frame_done === 1'b1) done_pulses++;
    end
  end

  // One frame: sof, shuffled in-range/out-of-range writes with random gaps, eof, blanking.
  task automatic run_frame(input int n_in, input int n_oor, input bit we_on_eof,
                           input bit pass_in, input int snap_at);
    wr_t q[$];
    wr_t w;
    bit pass;
    pass = pass_in;
    for (int i = 0; i < n_in; i++) begin
      w.addr = AW'(i % FP);
      w.data = DW'($urandom);
      q.push_back(w);
    end
    for (int i = 0; i < n_oor; i++) begin
      w.addr = AW'(FP + $urandom_range(0, 255 - FP));
      w.data = DW'($urandom);
      q.insert($urandom_range(0, q.size()), w);
    end
    vsync = 1'b0;
    step(2);
    for (int k = 0; k < q.size(); k++) begin
      if (k == snap_at) begin
        pulse(1'b1, 1'b0);
        pass = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step(1);
      bus.cap_we   = 1'b1;
      bus.cap_addr = q[k].addr;
      bus.cap_data = q[k].data;
      if (pass && (int'(q[k].addr) < FP)) exp_q.push_back(q[k]);
      if (we_on_eof && (k == q.size() - 1)) raise_vsync();
      step(1);
      bus.cap_we = 1'b0;
    end
    if (!(we_on_eof && (q.size() > 0))) begin
      raise_vsync();
      step(1);
    end
    step(3);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int d0;
    int pc0;

    vecs[0] = '{32, 0, 1'b0, 32, 1'b0};
    vecs[1] = '{20, 0, 1'b0, 20, 1'b1};
    vecs[2] = '{32, 3, 1'b0, 32, 1'b0};
    vecs[3] = '{40, 0, 1'b0, 32, 1'b0};
    vecs[4] = '{32, 0, 1'b1, 32, 1'b0};
    vecs[5] = '{31, 2, 1'b1, 31, 1'b1};
    vecs[6] = '{0,  0, 1'b0, 0,  1'b1};

    reset_n = 1'b0; vsync = 1'b1; snap_req = 1'b0; live_req = 1'b0;
    bus.cap_we = 1'b0; bus.cap_addr = '0; bus.cap_data = '0;
    step(3);
    check("rst_bram_we", 32'(bus.bram_we), 0);
    check("rst_bram_addr", 32'(bus.bram_addr), 0);
    check("rst_freeze", 32'(freeze_frame), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_pixels", 32'(pixel_count), 0);
    check("rst_frames", 32'(frame_count), 0);
    check("rst_short", 32'(short_frame), 0);
    reset_n = 1'b1;
    step(2);

    // Live mode: two frames straight through.
    run_frame(FP, 2, 1'b0, 1'b1, -1);
    run_frame(FP, 0, 1'b0, 1'b1, -1);
    check("live_frames", 32'(frame_count), 32'(model_frames & 16'hFFFF));
    check("live_frame_count2", 32'(frame_count), 2);
    check("live_freeze", 32'(freeze_frame), 0);
    check("live_no_done", 32'(done_pulses), 0);

    // Snapshot requested mid-frame: rest of that frame suppressed, next frame captured.
    run_frame(FP, 0, 1'b0, 1'b1, 10);
    check("armed_busy", 32'(busy), 1);
    check("armed_no_done", 32'(done_pulses), 0);
    run_frame(FP, 0, 1'b0, 1'b1, -1);
    check("snap_done", 32'(done_pulses), 1);
    check("snap_pixels", 32'(pixel_count), FP);
    check("snap_short", 32'(short_frame), 0);
    check("snap_freeze", 32'(freeze_frame), 1);

    // Held frame: three more frames must not reach the buffer.
    for (int f = 0; f < 3; f++) run_frame(FP, 1, 1'b0, 1'b0, -1);
    check("hold_frames", 32'(frame_count), 32'(model_frames & 16'hFFFF));
    check("hold_pixels", 32'(pixel_count), FP);
    check("hold_done", 32'(done_pulses), 1);
    check("hold_freeze", 32'(freeze_frame), 1);

    foreach (vecs[i]) begin
      pulse(1'b0, 1'b1);
      check("vec_live_unfrozen", 32'(freeze_frame), 0);
      pulse(1'b1, 1'b0);
      check("vec_armed_busy", 32'(busy), 1);
      d0 = done_pulses;
      run_frame(vecs[i].n_in, vecs[i].n_oor, vecs[i].we_on_eof, 1'b1, -1);
      check($sformatf("vec%0d_done", i), 32'(done_pulses - d0), 1);
      check($sformatf("vec%0d_pixels", i), 32'(pixel_count), 32'(vecs[i].exp_pixels));
      check($sformatf("vec%0d_short", i), 32'(short_frame), 32'(vecs[i].exp_short));
      check($sformatf("vec%0d_freeze", i), 32'(freeze_frame), 1);
      check($sformatf("vec%0d_frames", i), 32'(frame_count), 32'(model_frames & 16'hFFFF));
    end

    // Snap and live together in HOLD: snap wins, so a blanking write is suppressed.
    pulse(1'b1, 1'b1);
    check("both_busy", 32'(busy), 1);
    check("both_freeze", 32'(freeze_frame), 0);
    bus.cap_we = 1'b1; bus.cap_addr = 8'd3; bus.cap_data = 12'h5A5;
    step(1);
    bus.cap_we = 1'b0;
    step(1);
    vsync = 1'b0;
    step(2);
    bus.cap_we = 1'b1; bus.cap_addr = AW'(FP); bus.cap_data = 12'h111;
    step(1);
    bus.cap_addr = 8'd5; bus.cap_data = 12'h222;
    exp_q.push_back('{8'd5, 12'h222});
    step(1);
    bus.cap_we = 1'b0;
    raise_vsync();
    step(1);
    check("eof_done_high", 32'(frame_done), 1);
    check("eof_freeze", 32'(freeze_frame), 1);
    step(1);
    check("eof_done_low", 32'(frame_done), 0);
    check("oor_pixels", 32'(pixel_count), 1);
    check("oor_short", 32'(short_frame), 1);
    check("oor_drain", 32'(exp_q.size()), 0);

    // Reset in the middle of a capture.
    pulse(1'b1, 1'b0);
    vsync = 1'b0;
    step(2);
    bus.cap_we = 1'b1; bus.cap_addr = 8'd1; bus.cap_data = 12'h333;
    exp_q.push_back('{8'd1, 12'h333});
    step(1);
    bus.cap_we = 1'b0;
    step(2);
    d0 = done_pulses;
    reset_n = 1'b0;
    model_frames = 0;
    step(1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_freeze", 32'(freeze_frame), 0);
    check("mid_rst_pixels", 32'(pixel_count), 0);
    check("mid_rst_frames", 32'(frame_count), 0);
    check("mid_rst_we", 32'(bus.bram_we), 0);
    check("mid_rst_short", 32'(short_frame), 0);
    reset_n = 1'b1;
    step(2);
    raise_vsync();
    step(3);
    check("post_rst_no_done", 32'(done_pulses - d0), 0);
    check("post_rst_frames", 32'(frame_count), 32'(model_frames & 16'hFFFF));
    check("post_rst_busy", 32'(busy), 0);

    // frame_count wrap from a preloaded 0xFFFF.
    pc0 = int'(pixel_count);
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    model_frames = 16'hFFFF;
    step(1);
    vsync = 1'b0;
    step(2);
    raise_vsync();
    step(2);
    check("wrap_frames", 32'(frame_count), 32'(model_frames & 16'hFFFF));
    check("wrap_pixels", 32'(pixel_count), 32'(pc0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
